piso_shifter: RTL and testbench
===============================

Name: piso_shifter

Overview:
Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enable tick, with a bit strobe, a frame-start marker and an end-of-frame pulse. It is the transmit end of the team's serial bit link and is paced by an external bit-rate enable (en).

Parameters:
WIDTH, 8, data word width in bits; must be ≥2.
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
clk  input  1  single system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
en  input  1  bit-rate tick; one bit is shifted per clk edge where en=1 in SHIFT.
din  input  WIDTH  parallel word; sampled only on load accept.
load_valid  input  1  producer has a word on din.
load_ready  output  1  block can accept a word (registered).
sout  output  1  serial data bit (registered).
sout_n  output  1  continuous complement of sout.
sout_valid  output  1  one-cycle strobe marking a new sout bit.
frame_start  output  1  one-cycle strobe, coincident with sout_valid of the first bit.
done  output  1  one-cycle pulse, the cycle after the last bit's sout_valid.
busy  output  1  high while in SHIFT.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame) drives every output and state element as follows:
  - state=IDLE, load_ready=1, sout=0 (so sout_n=1), sout_valid=0, frame_start=0, done=0, busy=0.
  - Shift register and bit counter cleared.
  - A partial frame is aborted; no done pulse is produced.
- States:
  - IDLE: load_ready=1, busy=0.
  - SHIFT: load_ready=0, busy=1.
- Load accept: load_valid=1 and load_ready=1 at a posedge.
  - shreg<=din, cnt<=0, state<=SHIFT.
  - load_ready=0 and busy=1 from the next cycle.
- en in the accept cycle is ignored. The first bit goes out on the first en=1 edge strictly after accept.
- SHIFT with en=1 at a posedge:
  - sout<=current head bit (MSB or LSB per MSB_FIRST).
  - shreg shifts toward the head.
  - sout_valid<=1; frame_start<=(cnt==0); cnt<=cnt+1.
- SHIFT with en=0: sout holds, sout_valid=0, frame_start=0, cnt holds.
- Last bit (cnt==WIDTH-1 with en=1):
  - That bit is emitted as above and state<=IDLE.
  - load_ready=1 and busy=0 from the next cycle.
  - done=1 for exactly one cycle, coincident with that last bit's sout_valid+1 cycle.
- Back-to-back loads:
  - The earliest re-accept is the cycle in which done=1 (load_ready=1 there).
  - Minimum frame period is WIDTH+1 clk cycles with en tied high.
- load_valid while busy is ignored. din changes while busy have no effect.
- en=1 in IDLE: no effect; sout holds its last value.
- sout keeps the last transmitted bit between frames. sout_valid is the only qualifier.
- cnt width is clog2(WIDTH); cnt never wraps past WIDTH-1.

Decomposition:
- Shared package piso_pkg:
  - state typedef {IDLE, SHIFT}.
  - Default WIDTH constant.
  - Function computing counter width clog2(WIDTH).
- One natural sub-module, piso_bit_counter: clears on load, increments on en, flags last = (cnt==WIDTH-1).
- Shift register, FSM and output registers stay in the top module.

Test Plan:
- Reset check: assert reset, then release with no load → load_ready=1, sout=0, sout_n=1, sout_valid/frame_start/done/busy=0.
- MSB_FIRST=1, din=8'h1E, en=1 always:
  - sout_valid bits read 0,0,0,1,1,1,1,0.
  - frame_start on the first bit; done one cycle after the 8th bit; busy high for 8 cycles.
- MSB_FIRST=0, din=8'h1E, en=1 always → bits 0,1,1,1,1,0,0,0.
- en pulsed every 4th cycle, din=8'hA5:
  - 8 sout_valid strobes spaced 4 cycles apart; sout stable between strobes.
  - Frame lasts 32 cycles.
- Load 8'hFF, hold load_valid high, change din to 8'h00 mid-frame:
  - Frame 1 is all 1s.
  - 8'h00 is accepted in the done cycle and frame 2 is all 0s.
  - No gap beyond 1 cycle.
- Reset asserted after 3 bits of 8'hF0:
  - Outputs return to reset values asynchronously; no done pulse.
  - A subsequent load of 8'h0F transmits cleanly from bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the piso_shifter serial transmitter.
//   state_t             - transmitter FSM states
//   PISO_DEFAULT_WIDTH  - default data word width
//   piso_cnt_width()    - bit-counter width for a given word width
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PISO_DEFAULT_WIDTH = 8;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int piso_cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts transmitted bits within one frame.
//   clk, reset  - system clock, asynchronous active-high reset
//   clear_i     - restart the count at zero (word accepted)
//   inc_i       - one bit transmitted this cycle
//   cnt_o       - number of bits already transmitted in the frame
//   last_o      - the next bit transmitted is the final bit of the word
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH,
    parameter int CW    = piso_cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign cnt_o  = cnt_q;

    // Saturates at WIDTH-1: the FSM leaves SHIFT on the last bit, so the
    // count is cleared again before it is ever needed past that point.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in/serial-out transmitter paced by a bit-rate enable.
//   clk, reset   - system clock, asynchronous active-high reset
//   en           - bit-rate tick; one bit shifted per enabled edge in SHIFT
//   din          - parallel word, sampled only when a load is accepted
//   load_valid   - producer offers a word on din
//   load_ready   - a word can be accepted (registered)
//   sout, sout_n - serial bit (registered) and its complement
//   sout_valid   - one-cycle strobe marking a new sout bit
//   frame_start  - strobe coincident with the first bit of a frame
//   done         - one-cycle pulse the cycle after the last bit's strobe
//   busy         - frame in progress
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_n,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int CW = piso_cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;

    logic             accept;
    logic             shift_en;
    logic [CW-1:0]    cnt;
    logic             cnt_last;

    assign accept   = load_valid && load_ready_q;
    assign shift_en = (state_q == SHIFT) && en;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (accept),
        .inc_i   (shift_en),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        sout_d        = sout_q;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        // A strobe seen while already back in IDLE can only be the final bit,
        // so this flags the cycle after the last bit even if a new word is
        // accepted on that same edge.
        done_d        = sout_valid_q && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = din;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (MSB_FIRST) begin
                        sout_d  = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sout_d  = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    sout_valid_d  = 1'b1;
                    frame_start_d = (cnt == '0);
                    if (cnt_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            load_ready_q  <= load_ready_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign sout        = sout_q;
    assign sout_n      = ~sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
    assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_shifter.sv
module tb_piso_shifter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       load_valid = 1'b0;

    logic m_rd, m_sout, m_sout_n, m_v, m_fs, m_dn, m_bz;
    logic l_rd, l_sout, l_sout_n, l_v, l_fs, l_dn, l_bz;

    int n_pass  = 0;
    int n_total = 0;

    // Last transmitted bit expected on each DUT (held between frames).
    logic exp_m = 1'b0;
    logic exp_l = 1'b0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .en(en), .din(din), .load_valid(load_valid),
        .load_ready(m_rd), .sout(m_sout), .sout_n(m_sout_n), .sout_valid(m_v),
        .frame_start(m_fs), .done(m_dn), .busy(m_bz)
    );

    piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .en(en), .din(din), .load_valid(load_valid),
        .load_ready(l_rd), .sout(l_sout), .sout_n(l_sout_n), .sout_valid(l_v),
        .frame_start(l_fs), .done(l_dn), .busy(l_bz)
    );

    function automatic logic [13:0] obs();
        return {m_sout, m_sout_n, m_v, m_fs, m_dn, m_bz, m_rd,
                l_sout, l_sout_n, l_v, l_fs, l_dn, l_bz, l_rd};
    endfunction

    function automatic logic [13:0] expv(input logic v, input logic fs, input logic dn,
                                         input logic bz, input logic rd);
        return {exp_m, ~exp_m, v, fs, dn, bz, rd,
                exp_l, ~exp_l, v, fs, dn, bz, rd};
    endfunction

    // Transmit one word. Entry: negedge before the accept edge, or (preloaded)
    // negedge right after an accept made in the previous frame's done cycle.
    // Exit: negedge after the done cycle has been checked.
    task automatic run_frame(input string name, input logic [7:0] d, input int period,
                             input bit preloaded, input bit hold_next,
                             input logic [7:0] next_d, output int cycles);
        int k;
        logic en_now;
        logic [13:0] e;
        if (!preloaded) begin
            din = d; load_valid = 1'b1; en = 1'b1;
            @(posedge clk); @(negedge clk);
            e = expv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_total++;
            if (obs() !== e) $display("FAIL %s accept: got %b want %b", name, obs(), e);
            else n_pass++;
        end
        load_valid = hold_next;
        din = hold_next ? next_d : 8'($urandom);
        cycles = 0;
        k = 0;
        while (k < 8) begin
            if (period == 0) en_now = ($urandom_range(0, 1) == 1) || (cycles > 200);
            else             en_now = ((cycles % period) == (period - 1));
            en = en_now;
            @(posedge clk); @(negedge clk);
            cycles++;
            if (en_now) begin
                exp_m = d[7 - k];
                exp_l = d[k];
            end
            e = expv(en_now, en_now && (k == 0), 1'b0,
                     !(en_now && (k == 7)), en_now && (k == 7));
            n_total++;
            if (obs() !== e)
                $display("FAIL %s bit%0d cyc%0d: got %b want %b", name, k, cycles, obs(), e);
            else n_pass++;
            if (en_now) k++;
            if (!hold_next) din = 8'($urandom);
        end
        en = 1'($urandom);
        @(posedge clk); @(negedge clk);
        e = expv(1'b0, 1'b0, 1'b1, hold_next, !hold_next);
        n_total++;
        if (obs() !== e) $display("FAIL %s done: got %b want %b", name, obs(), e);
        else n_pass++;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        reset = 1'b1; en = 1'b0; load_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_m = 1'b0; exp_l = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            e = expv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_total++;
            if (obs() !== e) $display("FAIL reset_state: got %b want %b", obs(), e);
            else n_pass++;
        end
    endtask

    task automatic test_basic_1e();
        int c;
        run_frame("basic_1e", 8'h1E, 1, 1'b0, 1'b0, 8'h00, c);
        n_total++;
        if (c !== 8) $display("FAIL basic_1e_len: got %0d want %0d", c, 8);
        else n_pass++;
    endtask

    task automatic test_idle_en();
        logic [13:0] e;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; din = 8'($urandom); load_valid = 1'b0;
            @(posedge clk); @(negedge clk);
            e = expv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_total++;
            if (obs() !== e) $display("FAIL idle_en cyc%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
    endtask

    task automatic test_en_paced();
        int c;
        run_frame("paced_a5", 8'hA5, 4, 1'b0, 1'b0, 8'h00, c);
        n_total++;
        if (c !== 32) $display("FAIL paced_a5_len: got %0d want %0d", c, 32);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c;
        run_frame("b2b_ff", 8'hFF, 1, 1'b0, 1'b1, 8'h00, c);
        run_frame("b2b_00", 8'h00, 1, 1'b1, 1'b0, 8'h00, c);
    endtask

    task automatic test_reset_midframe();
        logic [13:0] e;
        int c;
        din = 8'hF0; load_valid = 1'b1; en = 1'b0;
        @(posedge clk); @(negedge clk);
        load_valid = 1'b0; en = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        exp_m = 1'b0; exp_l = 1'b0;
        e = expv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (obs() !== e) $display("FAIL async_reset: got %b want %b", obs(), e);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_total++;
            if (obs() !== e) $display("FAIL no_done_after_reset cyc%0d: got %b want %b", i, obs(), e);
            else n_pass++;
        end
        run_frame("post_reset_0f", 8'h0F, 1, 1'b0, 1'b0, 8'h00, c);
    endtask

    task automatic test_random();
        logic [7:0] cur_d, nxt_d;
        bit pre, hold;
        int c, per;
        cur_d = 8'($urandom);
        pre = 1'b0;
        for (int f = 0; f < 12; f++) begin
            nxt_d = 8'($urandom);
            hold  = (f < 11) ? 1'($urandom) : 1'b0;
            per   = $urandom_range(0, 3);
            run_frame("random", cur_d, per, pre, hold, nxt_d, c);
            pre   = hold;
            cur_d = nxt_d;
            if (!hold) begin
                en = 1'($urandom);
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_1e();
        test_idle_en();
        test_en_paced();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
